// File: rtl/pipeline_lca_adder_hs.sv
// Pipelined carry-lookahead add/subtract with valid/ready flow control.
// One CHUNK of the sum is resolved per stage; operands, partial sum, carry and tag travel together.
module pipeline_lca_adder_hs #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned NSTAGE = WIDTH / CHUNK;
  localparam int unsigned NGROUP = CHUNK / 4;

  generate
    if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0) || ((CHUNK % 4) != 0) || (TAG_W < 1)) begin : gen_bad_param
      $error("pipeline_lca_adder_hs: WIDTH must be a multiple of CHUNK, CHUNK a multiple of 4, TAG_W >= 1");
    end
  endgenerate

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t             st_q [0:NSTAGE];
  beat_t             nxt  [0:NSTAGE];
  logic [NSTAGE:0]   valid_q;
  logic [NSTAGE:0]   load;

  // One CHUNK of addition: 4-bit lookahead groups, group carries rippled.
  function automatic logic [CHUNK:0] cla_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    logic [CHUNK-1:0] s;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [3:0]       c;
    logic             carry;
    s     = '0;
    carry = ci;
    for (int unsigned gi = 0; gi < NGROUP; gi++) begin
      p    = x[gi*4 +: 4] ^ y[gi*4 +: 4];
      g    = x[gi*4 +: 4] & y[gi*4 +: 4];
      c[0] = carry;
      c[1] = g[0] | (p[0] & carry);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
      carry = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & carry);
      s[gi*4 +: 4] = p ^ c;
    end
    return {carry, s};
  endfunction

  // Resolve chunk idx of a travelling beat; ovf is only meaningful once the MSB chunk is done.
  function automatic beat_t stage_step(input beat_t cur, input int unsigned idx);
    beat_t          r;
    logic [CHUNK:0] res;
    r   = cur;
    res = cla_chunk(cur.a[idx*CHUNK +: CHUNK], cur.b[idx*CHUNK +: CHUNK], cur.c);
    r.s[idx*CHUNK +: CHUNK] = res[CHUNK-1:0];
    r.c   = res[CHUNK];
    r.ovf = (cur.a[WIDTH-1] == cur.b[WIDTH-1]) && (r.s[WIDTH-1] != cur.a[WIDTH-1]);
    return r;
  endfunction

  // Ready chain: an empty stage always loads, a full one loads only if its successor does.
  always_comb begin
    logic ld;
    load = '0;
    ld   = out_ready;
    for (int unsigned j = 0; j <= NSTAGE; j++) begin
      ld               = !valid_q[NSTAGE-j] || ld;
      load[NSTAGE-j]   = ld;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k <= NSTAGE; k++) begin
      nxt[k] = '0;
    end
    nxt[0].a   = a;
    nxt[0].b   = sub ? ~b : b;
    nxt[0].s   = '0;
    nxt[0].c   = sub ? 1'b1 : cin;
    nxt[0].ovf = 1'b0;
    nxt[0].tag = tag;
    for (int unsigned k = 1; k <= NSTAGE; k++) begin
      nxt[k] = stage_step(st_q[k-1], k - 1);
    end
  end

  // Data registers only update on a real beat so idle outputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i <= NSTAGE; i++) begin
        st_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) st_q[0] <= nxt[0];
      end
      for (int unsigned i = 1; i <= NSTAGE; i++) begin
        if (load[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) st_q[i] <= nxt[i];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[NSTAGE];
  assign sum       = st_q[NSTAGE].s;
  assign cout      = st_q[NSTAGE].c;
  assign ovf       = st_q[NSTAGE].ovf;
  assign tag_out   = st_q[NSTAGE].tag;

endmodule

// File: tb/tb_pipeline_lca_adder_hs.sv
// Bench for pipeline_lca_adder_hs: directed vector table plus randomized scoreboard traffic.
module tb_pipeline_lca_adder_hs;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned CHUNK  = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned NSTAGE = WIDTH / CHUNK;
  localparam int unsigned LAT    = NSTAGE + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [TAG_W-1:0] tag_out;

  pipeline_lca_adder_hs #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } res_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  res_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_cnt  = 0;
  int   emit_cnt = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide addition of the effective operands.
  function automatic res_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vcin, input logic vsub, input logic [TAG_W-1:0] vtag);
    res_t             r;
    logic [WIDTH-1:0] beff;
    logic [WIDTH:0]   full;
    beff  = vsub ? ~vb : vb;
    full  = {1'b0, va} + {1'b0, beff} + (WIDTH+1)'(vsub ? 1'b1 : vcin);
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (va[WIDTH-1] == beff[WIDTH-1]) && (r.sum[WIDTH-1] != va[WIDTH-1]);
    r.tag  = vtag;
    return r;
  endfunction

  // One clock of scoreboarded traffic: drive, then judge the handshakes of the coming edge.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vcin, input logic vsub, input logic [TAG_W-1:0] vtag,
                       input logic ordy);
    res_t e;
    @(posedge clk); #1;
    in_valid = iv; a = va; b = vb; cin = vcin; sub = vsub; tag = vtag; out_ready = ordy;
    #1;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", WIDTH'(out_valid), '0);
      end else begin
        e = q[0];
        check("sb_sum", sum, e.sum);
        check("sb_cout", WIDTH'(cout), WIDTH'(e.cout));
        check("sb_ovf", WIDTH'(ovf), WIDTH'(e.ovf));
        check("sb_tag", WIDTH'(tag_out), WIDTH'(e.tag));
        if (out_ready) begin
          void'(q.pop_front());
          emit_cnt++;
        end
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(va, vb, vcin, vsub, vtag));
      acc_cnt++;
    end
  endtask

  task automatic rnd_cycle(input logic iv, input logic ordy);
    cycle(iv, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()), 1'($urandom()),
          TAG_W'($urandom()), ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * LAT && q.size() > 0; i++) rnd_cycle(1'b0, 1'b1);
    rnd_cycle(1'b0, 1'b1);
    check("drain_empty", WIDTH'(q.size()), '0);
  endtask

  // Single beat into an idle pipe; checks latency (edges counted from the accept edge) and result.
  task automatic apply_vec(input vec_t v, input string name);
    int edges;
    @(posedge clk); #1;
    in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub; tag = v.tag; out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, WIDTH'(in_ready), WIDTH'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, "_latency"}, WIDTH'(edges), WIDTH'(LAT));
    check({name, "_sum"}, sum, v.exp_sum);
    check({name, "_cout"}, WIDTH'(cout), WIDTH'(v.exp_cout));
    check({name, "_ovf"}, WIDTH'(ovf), WIDTH'(v.exp_ovf));
    check({name, "_tag"}, WIDTH'(tag_out), WIDTH'(v.tag));
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];

  initial begin
    int a0, e0;
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'h1, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h5, 64'h7, 1'b0, 1'b1, 4'h3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'h5, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h0, 64'h0, 1'b1, 1'b0, 4'h7, 64'h1, 1'b0, 1'b0};
    vecs[4] = '{64'h7, 64'h7, 1'b0, 1'b1, 4'h9, 64'h0, 1'b1, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 4'hA, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'hC, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'hF, 64'h0, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", WIDTH'(out_valid), '0);
    check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    check("rst_sum", sum, '0);
    check("rst_cout", WIDTH'(cout), '0);
    check("rst_ovf", WIDTH'(ovf), '0);
    check("rst_tag", WIDTH'(tag_out), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Full-rate streaming
    a0 = acc_cnt; e0 = emit_cnt;
    for (int i = 0; i < 1000; i++) rnd_cycle(1'b1, 1'b1);
    check("stream_accepts", WIDTH'(acc_cnt - a0), WIDTH'(1000));
    check("stream_emits", WIDTH'(emit_cnt - e0), WIDTH'(1000 - LAT));
    drain();

    // Back-pressure fill: capacity then in_ready low
    a0 = acc_cnt; e0 = emit_cnt;
    for (int i = 0; i < 2 * LAT; i++) rnd_cycle(1'b1, 1'b0);
    check("stall_accepts", WIDTH'(acc_cnt - a0), WIDTH'(LAT));
    check("stall_in_ready", WIDTH'(in_ready), '0);
    check("stall_no_emit", WIDTH'(emit_cnt - e0), '0);
    drain();
    check("stall_drain_emits", WIDTH'(emit_cnt - e0), WIDTH'(LAT));

    // Random valid/ready toggling
    a0 = acc_cnt; e0 = emit_cnt;
    for (int i = 0; i < 600; i++) rnd_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    drain();
    check("toggle_conserved", WIDTH'(emit_cnt - e0), WIDTH'(acc_cnt - a0));

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) rnd_cycle(1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", WIDTH'(out_valid), '0);
    check("midrst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", WIDTH'(out_valid), '0);
    end
    apply_vec(vecs[2], "post_rst_vec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
